seg7_to_twos_encoder: RTL and testbench
=======================================

// Module: seg7_to_twos_encoder
// PURPOSE
//  Inverse of the two's-complement 7-seg display path: snoops an active-low
//  7-seg digit/sign pattern pair and recovers the 4-bit two's-complement value.
//  - Debounces the pattern pair and emits each new stable pair once over a
//    valid/ready handshake.
//  - Flags illegal patterns.
//  - Used for display loopback checking and for pattern-driven value entry.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before capture (>=1)
// PORTS
//  CLOCK_50   in   1  single clock, all logic on rising edge
//  reset      in   1  synchronous, active-high
//  HEX0_IN    in   7  digit pattern, active-low, bit6=g .. bit0=a
//  HEX1_IN    in   7  sign pattern, active-low (0111111 = minus, 1111111 = blank)
//  out_ready  in   1  consumer accepts out_value when high with out_valid
//  out_valid  out  1  out_value/out_err hold a captured result
//  out_value  out  4  recovered two's-complement value (0000 when out_err)
//  out_err    out  1  captured pair was not a legal encoding
//  err_count  out  8  saturating count of illegal captures
// BEHAVIOUR
//  Reset (sync, high):
//  - out_valid=0, out_value=0, out_err=0, err_count=0, cnt=0.
//  - Sample regs = 7'h7F/7'h7F; have_last=0; state=TRACK.
//  - Reset asserted mid-EMIT discards the pending result; out_valid is 0
//    after that edge.
//  Sampling and stability counter:
//  - Every edge, {HEX1_IN,HEX0_IN} registers into seg_q.
//  - If the inputs equal seg_q, cnt increments, saturating at STABLE_CYCLES;
//    otherwise cnt<=0.
//  Legal table, digit patterns: 0=1000000 1=1111001 2=0100100 3=0110000
//  4=0011001 5=0010010 6=0000010 7=1111000 8=0000000.
//  - blank + digit 0..7 -> 0..7.
//  - minus + digit 1..8 -> 16-d (1111..1000).
//  - Illegal: minus+0, blank+8, any other sign or digit pattern.
//  FSM:
//  - TRACK: if cnt==STABLE_CYCLES and (!have_last or seg_q!=last_pair):
//    - latch value/err from the lookup; last_pair<=seg_q; have_last<=1;
//    - err_count++ (saturating at 8'hFF) if illegal; ->EMIT.
//  - EMIT: out_valid=1, outputs frozen.
//    - On out_ready, ->TRACK and out_valid=0 next cycle.
//    - Sampling and cnt keep running in EMIT, so a pair that stabilised
//      during backpressure is captured the cycle after TRACK is re-entered.
//  Latency:
//  - A new pair held constant from cycle 0 gives out_valid high after edge
//    STABLE_CYCLES+2 (6 at the default).
//  - Throughput is at most one result per 2 cycles.
//  Rules:
//  - The same stable pair is never re-emitted until a different pair has
//    been captured or reset has occurred.
//  - A pair shorter than STABLE_CYCLES+1 samples is ignored (glitch).
//  - A pair that changes back to last_pair before capture produces nothing.
//  - out_valid never drops without out_ready, except on reset.
// STRUCTURE
//  seg7_pkg:
//  - SEG_0..SEG_8, SEG_MINUS, SEG_BLANK localparams.
//  - typedef enum logic {TRACK, EMIT} enc_state_t.
//  seg7_pattern_lookup (comb sub-module): {sign,digit} -> {value[3:0], illegal}.
//  Top: sample regs, stability counter (width $clog2(STABLE_CYCLES+1)), FSM,
//  output regs, err_count.
// TESTING
//  1. Reset; hold HEX1=1111111, HEX0=0110000, out_ready=1 -> single out_valid
//     pulse at cycle 6, out_value=0011, out_err=0; no repeat while held.
//  2. HEX1=0111111, HEX0=0000000 stable -> out_value=1000 (-8), out_err=0.
//     HEX0=1111001 -> out_value=1111 (-1).
//  3. Glitch: alternate digit 5/6 every 3 cycles -> no out_valid.
//     Then hold 6 -> single emission of 0110.
//  4. out_ready=0; hold 5 (0010010), then hold -2 (minus, 0100100) ->
//     out_valid stays high with 0101 unchanged.
//     Raise out_ready -> next emission 1110.
//  5. minus+1000000, then blank+0000000 -> two emissions with out_err=1,
//     out_value=0000; err_count=2.
//  6. Reset asserted during EMIT holding 0011 -> out_valid=0 the next cycle.
//     Deassert reset with the same pair held -> 0011 re-emitted at cycle 6.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, state type and digit decoder for the 7-seg to
// two's-complement snooping encoder. Patterns are active-low, bit6=g .. bit0=a.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {TRACK, EMIT} enc_state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] digit;
  } digit_dec_t;

  // Map a digit pattern to its magnitude 0..8; ok=0 for anything else.
  function automatic digit_dec_t seg_to_digit(input logic [6:0] seg);
    digit_dec_t d;
    d = '{ok: 1'b1, digit: 4'd0};
    case (seg)
      SEG_0:   d.digit = 4'd0;
      SEG_1:   d.digit = 4'd1;
      SEG_2:   d.digit = 4'd2;
      SEG_3:   d.digit = 4'd3;
      SEG_4:   d.digit = 4'd4;
      SEG_5:   d.digit = 4'd5;
      SEG_6:   d.digit = 4'd6;
      SEG_7:   d.digit = 4'd7;
      SEG_8:   d.digit = 4'd8;
      default: d = '{ok: 1'b0, digit: 4'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational decode of a {sign, digit} pattern pair into a 4-bit
// two's-complement value plus an illegal flag. Value is 0 when illegal.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] i_sign,
  input  logic [6:0] i_digit,
  output logic [3:0] o_value,
  output logic       o_illegal
);

  digit_dec_t w_dec;

  assign w_dec = seg_to_digit(i_digit);

  // Blank sign accepts 0..7; minus accepts 1..8 and yields 16-d.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_value   = 4'd0;
    o_illegal = 1'b1;
    if (i_sign == SEG_BLANK && w_dec.ok && w_dec.digit <= 4'd7) begin
      o_value   = w_dec.digit;
      o_illegal = 1'b0;
    end else if (i_sign == SEG_MINUS && w_dec.ok && w_dec.digit != 4'd0) begin
      o_value   = 4'(5'd16 - {1'b0, w_dec.digit});
      o_illegal = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_to_twos_encoder.sv
// Snoops an active-low sign/digit 7-seg pair, waits for it to be stable,
// and emits each newly stable pair once as a two's-complement value over
// a valid/ready handshake. Illegal pairs are flagged and counted.
module seg7_to_twos_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] HEX0_IN,
  input  logic [6:0] HEX1_IN,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_value,
  output logic       out_err,
  output logic [7:0] err_count
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [13:0]      w_pair;
  logic [13:0]      r_seg_q;
  logic [CNT_W-1:0] r_cnt;
  logic [13:0]      r_last_pair;
  logic             r_have_last;
  enc_state_t       r_state;
  enc_state_t       w_state_next;
  logic             w_capture;
  logic [3:0]       w_lut_value;
  logic             w_lut_illegal;
  logic             r_out_valid;
  logic [3:0]       r_out_value;
  logic             r_out_err;
  logic [7:0]       r_err_count;

  assign w_pair = {HEX1_IN, HEX0_IN};

  seg7_pattern_lookup u_lookup (
    .i_sign    (r_seg_q[13:7]),
    .i_digit   (r_seg_q[6:0]),
    .o_value   (w_lut_value),
    .o_illegal (w_lut_illegal)
  );

  // Sample the pair every edge and count consecutive identical samples.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_seg_q <= {SEG_BLANK, SEG_BLANK};
      r_cnt   <= '0;
    end else begin
      r_seg_q <= w_pair;
      if (w_pair == r_seg_q) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= TRACK;
    else       r_state <= w_state_next;
  end

  // Next state: capture a new stable pair in TRACK, wait for ready in EMIT.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      TRACK: begin
        if (r_cnt == CNT_MAX && (!r_have_last || r_seg_q != r_last_pair)) begin
          w_capture    = 1'b1;
          w_state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) w_state_next = TRACK;
      end
      default: w_state_next = TRACK;
    endcase
  end

  // Latch the captured result, remember the pair, and count illegal captures.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_value <= 4'd0;
      r_out_err   <= 1'b0;
      r_err_count <= 8'd0;
      r_last_pair <= {SEG_BLANK, SEG_BLANK};
      r_have_last <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == EMIT);
      if (w_capture) begin
        r_out_value <= w_lut_value;
        r_out_err   <= w_lut_illegal;
        r_last_pair <= r_seg_q;
        r_have_last <= 1'b1;
        if (w_lut_illegal && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_seg7_to_twos_encoder.sv
// Directed bench for seg7_to_twos_encoder: stimulus pushes expected results
// into a queue, a monitor pops and compares on each valid/ready handshake.
module tb_seg7_to_twos_encoder;
  import seg7_pkg::*;

  logic       CLOCK_50;
  logic       reset;
  logic [6:0] HEX0_IN;
  logic [6:0] HEX1_IN;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_value;
  logic       out_err;
  logic [7:0] err_count;

  typedef struct packed {
    logic [3:0] value;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fails = 0;

  seg7_to_twos_encoder #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .HEX0_IN   (HEX0_IN),
    .HEX1_IN   (HEX1_IN),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic [6:0] sign, input logic [6:0] digit);
    HEX1_IN = sign;
    HEX0_IN = digit;
  endtask

  task automatic expect_out(input logic [3:0] value, input logic err);
    exp_t e;
    e.value = value;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted output must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL unexpected_output: got value=%b err=%b with nothing expected at %0t",
                   out_value, out_err, $time);
        end else begin
          e = exp_q.pop_front();
          check("mon_out{value,err}", 32'({out_value, out_err}), 32'({e.value, e.err}));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(SEG_BLANK, SEG_3);

    // Reset state.
    step(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // 1: blank+3 held from cycle 0 -> valid exactly after edge 6, no repeat.
    expect_out(4'b0011, 1'b0);
    reset = 1'b0;
    step(5);
    check("t1_valid_before_6", 32'(out_valid), 32'd0);
    step(1);
    check("t1_valid_at_6", 32'(out_valid), 32'd1);
    step(12);
    check("t1_no_repeat_q", 32'(exp_q.size()), 32'd0);
    check("t1_valid_low", 32'(out_valid), 32'd0);

    // 2: minus+8 -> -8, then minus+1 -> -1.
    drive(SEG_MINUS, SEG_8);
    expect_out(4'b1000, 1'b0);
    step(10);
    drive(SEG_MINUS, SEG_1);
    expect_out(4'b1111, 1'b0);
    step(10);

    // 3: 5/6 alternating every 3 cycles never stabilises; then hold 6.
    for (int k = 0; k < 6; k++) begin
      drive(SEG_BLANK, (k % 2 == 0) ? SEG_5 : SEG_6);
      step(3);
      check("t3_glitch_no_valid", 32'(out_valid), 32'd0);
    end
    expect_out(4'b0110, 1'b0);
    step(10);

    // 4: backpressure freezes 5 while -2 stabilises; -2 follows on ready.
    out_ready = 1'b0;
    drive(SEG_BLANK, SEG_5);
    expect_out(4'b0101, 1'b0);
    step(10);
    check("t4_valid_held", 32'(out_valid), 32'd1);
    check("t4_value_5",    32'(out_value), 32'b0101);
    drive(SEG_MINUS, SEG_2);
    expect_out(4'b1110, 1'b0);
    step(10);
    check("t4_valid_still", 32'(out_valid), 32'd1);
    check("t4_value_frozen", 32'(out_value), 32'b0101);
    out_ready = 1'b1;
    step(10);
    check("t4_drained_q", 32'(exp_q.size()), 32'd0);

    // 5: illegal minus+0 and blank+8.
    drive(SEG_MINUS, SEG_0);
    expect_out(4'b0000, 1'b1);
    step(10);
    drive(SEG_BLANK, SEG_8);
    expect_out(4'b0000, 1'b1);
    step(10);
    check("t5_err_count", 32'(err_count), 32'd2);

    // 6: reset during EMIT drops the result; same pair re-emitted after reset.
    out_ready = 1'b0;
    drive(SEG_BLANK, SEG_3);
    step(10);
    check("t6_valid_pre_rst", 32'(out_valid), 32'd1);
    check("t6_value_pre_rst", 32'(out_value), 32'b0011);
    reset = 1'b1;
    step(1);
    check("t6_valid_after_rst", 32'(out_valid), 32'd0);
    check("t6_err_count_rst",   32'(err_count), 32'd0);
    step(1);
    reset     = 1'b0;
    out_ready = 1'b1;
    expect_out(4'b0011, 1'b0);
    step(5);
    check("t6_valid_before_6", 32'(out_valid), 32'd0);
    step(1);
    check("t6_valid_at_6", 32'(out_valid), 32'd1);
    step(12);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
